// File: rtl/id_opfetch_pkg.sv
// id_opfetch_pkg: shared CPU definitions for the decode-side operand fetch
// stage: bus widths, active-low enable levels, reset level and FSM states.
// The build macro OPFETCH_FWD_EN selects EX/MEM forwarding in the stage.
package id_opfetch_pkg;

   localparam int WORD_DATA_W = 32;
   localparam int REG_ADDR_W  = 5;

   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   localparam logic RESET_ENABLE = 1'b0;

   typedef enum logic {
      OPF_RUN  = 1'b0,
      OPF_HOLD = 1'b1
   } opf_state_t;

endpackage

// File: rtl/id_opfetch_if.sv
// id_opfetch_if: pipeline-side signals of the operand fetch stage: IF/ID
// fields, register-file read port, EX/MEM forwarding sources, pipeline
// control and the ID/EX register outputs. The slave modport is the stage;
// the master modport is the surrounding pipeline.
interface id_opfetch_if
   import id_opfetch_pkg::*;
#(
   parameter int DATA_W = WORD_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) ();

   logic              IdValid;
   logic [ADDR_W-1:0] IdRsAddr0;
   logic [ADDR_W-1:0] IdRsAddr1;
   logic              IdRsUse0;
   logic              IdRsUse1;
   logic [ADDR_W-1:0] IdRdAddr;
   logic              IdRdWE_;
   logic              IdIsLoad;

   logic [ADDR_W-1:0] RdAddr0;
   logic [ADDR_W-1:0] RdAddr1;
   logic [DATA_W-1:0] RdData0;
   logic [DATA_W-1:0] RdData1;

   logic [DATA_W-1:0] ExFwdData;
   logic [ADDR_W-1:0] MemRdAddr;
   logic              MemRdWE_;
   logic [DATA_W-1:0] MemFwdData;

   logic              Flush;
   logic              DsStall;
   logic              IdStall;

   logic              ExValid;
   logic [DATA_W-1:0] ExOp0;
   logic [DATA_W-1:0] ExOp1;
   logic [ADDR_W-1:0] ExDstAddr;
   logic              ExDstWE_;
   logic              ExIsLoad;

   modport master (
      output IdValid, IdRsAddr0, IdRsAddr1, IdRsUse0, IdRsUse1,
      output IdRdAddr, IdRdWE_, IdIsLoad,
      output RdData0, RdData1,
      output ExFwdData, MemRdAddr, MemRdWE_, MemFwdData,
      output Flush, DsStall,
      input  RdAddr0, RdAddr1, IdStall,
      input  ExValid, ExOp0, ExOp1, ExDstAddr, ExDstWE_, ExIsLoad
   );

   modport slave (
      input  IdValid, IdRsAddr0, IdRsAddr1, IdRsUse0, IdRsUse1,
      input  IdRdAddr, IdRdWE_, IdIsLoad,
      input  RdData0, RdData1,
      input  ExFwdData, MemRdAddr, MemRdWE_, MemFwdData,
      input  Flush, DsStall,
      output RdAddr0, RdAddr1, IdStall,
      output ExValid, ExOp0, ExOp1, ExDstAddr, ExDstWE_, ExIsLoad
   );

endinterface

// File: rtl/id_opfetch_fwd_mux.sv
// opfetch_fwd_mux: operand source select for one register-file read port.
// Matches the source against the EX and MEM destinations and picks the
// newest value, flagging a hazard the stage must resolve with a bubble.
// With OPFETCH_FWD_EN defined only a load in EX is a hazard; otherwise any
// pending EX or MEM writer of the source is a hazard and no forwarding occurs.
module opfetch_fwd_mux
   import id_opfetch_pkg::*;
#(
   parameter int DATA_W = WORD_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic              src_use,
   input  logic [ADDR_W-1:0] src_addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic              ex_valid,
   input  logic [ADDR_W-1:0] ex_dst_addr,
   input  logic              ex_dst_we_,
   input  logic              ex_is_load,
   input  logic [DATA_W-1:0] ex_fwd_data,
   input  logic [ADDR_W-1:0] mem_dst_addr,
   input  logic              mem_dst_we_,
   input  logic [DATA_W-1:0] mem_fwd_data,
   output logic [DATA_W-1:0] operand,
   output logic              hazard
);

   logic ex_hit;
   logic mem_hit;

   assign ex_hit  = src_use && ex_valid && (ex_dst_we_ == ENABLE_) && (ex_dst_addr == src_addr);
   assign mem_hit = src_use && (mem_dst_we_ == ENABLE_) && (mem_dst_addr == src_addr);

`ifdef OPFETCH_FWD_EN
   // Newest producer wins: EX over MEM over the register file; a load in EX has no data yet
   always_comb begin
      operand = rf_data;
      hazard  = 1'b0;
      if (ex_hit && ex_is_load) begin
         hazard = 1'b1;
      end else if (ex_hit) begin
         operand = ex_fwd_data;
      end else if (mem_hit) begin
         operand = mem_fwd_data;
      end
   end
`else
   logic unused_fwd;

   assign unused_fwd = ^{ex_is_load, ex_fwd_data, mem_fwd_data};

   // Without forwarding the operand waits until its writer has left MEM
   always_comb begin
      operand = rf_data;
      hazard  = ex_hit || mem_hit;
   end
`endif

endmodule

// File: rtl/id_opfetch.sv
// id_opfetch: decode-side operand fetch stage. Drives the register-file read
// ports, resolves RAW hazards against EX and MEM (forwarding or bubbles) and
// holds the ID/EX operand register. OPFETCH_FWD_EN enables forwarding; when
// undefined, dependent instructions stall until the writer has left MEM.
module id_opfetch
   import id_opfetch_pkg::*;
#(
   parameter int DATA_W = WORD_DATA_W,
   parameter int ADDR_W = REG_ADDR_W
) (
   input  logic         clk,
   input  logic         reset_,
   id_opfetch_if.slave  bus
);

   opf_state_t        state_q;
   opf_state_t        state_d;

   logic [DATA_W-1:0] op0;
   logic [DATA_W-1:0] op1;
   logic              haz0;
   logic              haz1;
   logic              hazard;

   logic              id_stall;
   logic              take_bubble;
   logic              take_id;

   logic              ex_valid_q;
   logic [DATA_W-1:0] ex_op0_q;
   logic [DATA_W-1:0] ex_op1_q;
   logic [ADDR_W-1:0] ex_dst_addr_q;
   logic              ex_dst_we_q;
   logic              ex_is_load_q;

   assign bus.RdAddr0 = bus.IdRsAddr0;
   assign bus.RdAddr1 = bus.IdRsAddr1;

   opfetch_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd0 (
      .src_use      (bus.IdRsUse0),
      .src_addr     (bus.IdRsAddr0),
      .rf_data      (bus.RdData0),
      .ex_valid     (ex_valid_q),
      .ex_dst_addr  (ex_dst_addr_q),
      .ex_dst_we_   (ex_dst_we_q),
      .ex_is_load   (ex_is_load_q),
      .ex_fwd_data  (bus.ExFwdData),
      .mem_dst_addr (bus.MemRdAddr),
      .mem_dst_we_  (bus.MemRdWE_),
      .mem_fwd_data (bus.MemFwdData),
      .operand      (op0),
      .hazard       (haz0)
   );

   opfetch_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_fwd1 (
      .src_use      (bus.IdRsUse1),
      .src_addr     (bus.IdRsAddr1),
      .rf_data      (bus.RdData1),
      .ex_valid     (ex_valid_q),
      .ex_dst_addr  (ex_dst_addr_q),
      .ex_dst_we_   (ex_dst_we_q),
      .ex_is_load   (ex_is_load_q),
      .ex_fwd_data  (bus.ExFwdData),
      .mem_dst_addr (bus.MemRdAddr),
      .mem_dst_we_  (bus.MemRdWE_),
      .mem_fwd_data (bus.MemFwdData),
      .operand      (op1),
      .hazard       (haz1)
   );

   // An empty IF/ID slot never needs to wait for its sources
   assign hazard = bus.IdValid && (haz0 || haz1);

   // State register: RUN after reset
   always_ff @(posedge clk or negedge reset_) begin
      if (reset_ == RESET_ENABLE) begin
         state_q <= OPF_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: HOLD while downstream is busy, a flush always returns to RUN
   always_comb begin
      state_d = state_q;
      if (bus.Flush) begin
         state_d = OPF_RUN;
      end else begin
         case (state_q)
            OPF_RUN:  if (bus.DsStall)  state_d = OPF_HOLD;
            OPF_HOLD: if (!bus.DsStall) state_d = OPF_RUN;
            default:  state_d = OPF_RUN;
         endcase
      end
   end

   // Stage control: flush > downstream stall > hazard > advance; the cycle that
   // leaves HOLD behaves like RUN, so the decision rests on the inputs alone
   always_comb begin
      id_stall    = 1'b0;
      take_bubble = 1'b0;
      take_id     = 1'b0;
      if (bus.Flush) begin
         take_bubble = 1'b1;
      end else if (bus.DsStall) begin
         id_stall = 1'b1;
      end else if (hazard) begin
         id_stall    = 1'b1;
         take_bubble = 1'b1;
      end else begin
         take_id = 1'b1;
      end
   end

   assign bus.IdStall = id_stall;

   // ID/EX register: bubble, capture the ID instruction, or hold
   always_ff @(posedge clk or negedge reset_) begin
      if (reset_ == RESET_ENABLE) begin
         ex_valid_q    <= 1'b0;
         ex_op0_q      <= '0;
         ex_op1_q      <= '0;
         ex_dst_addr_q <= '0;
         ex_dst_we_q   <= DISABLE_;
         ex_is_load_q  <= 1'b0;
      end else if (take_bubble) begin
         ex_valid_q    <= 1'b0;
         ex_op0_q      <= '0;
         ex_op1_q      <= '0;
         ex_dst_addr_q <= '0;
         ex_dst_we_q   <= DISABLE_;
         ex_is_load_q  <= 1'b0;
      end else if (take_id) begin
         ex_valid_q    <= bus.IdValid;
         ex_op0_q      <= op0;
         ex_op1_q      <= op1;
         ex_dst_addr_q <= bus.IdRdAddr;
         ex_dst_we_q   <= bus.IdRdWE_ | ~bus.IdValid;
         ex_is_load_q  <= bus.IdIsLoad & bus.IdValid;
      end
   end

   assign bus.ExValid   = ex_valid_q;
   assign bus.ExOp0     = ex_op0_q;
   assign bus.ExOp1     = ex_op1_q;
   assign bus.ExDstAddr = ex_dst_addr_q;
   assign bus.ExDstWE_  = ex_dst_we_q;
   assign bus.ExIsLoad  = ex_is_load_q;

endmodule

// File: tb/tb_id_opfetch.sv
// tb_id_opfetch: scoreboard bench for id_opfetch. Each cycle the stimulus
// drives the pipeline inputs and queues what the stage should show during
// that cycle; a monitor samples shortly before the next rising edge and
// compares. Forwarding-specific sequences follow OPFETCH_FWD_EN.
module tb_id_opfetch;

   logic clk;
   logic reset_;

   id_opfetch_if bus ();

   id_opfetch dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus)
   );

   typedef struct {
      string       name;
      logic        valid;
      logic        we_n;
      logic        is_load;
      logic [4:0]  dst;
      bit          chk_ops;
      logic [31:0] op0;
      logic [31:0] op1;
      logic        stall;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Guard against a hung run
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic cmp(input string name, input string field, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("[TB] FAIL %s %s: got 0x%0h, expected 0x%0h", name, field, act, req);
      end
   endtask

   task automatic check_output(input exp_t e);
      cmp(e.name, "ExValid",  32'(bus.ExValid),  32'(e.valid));
      cmp(e.name, "ExDstWE_", 32'(bus.ExDstWE_), 32'(e.we_n));
      cmp(e.name, "ExIsLoad", 32'(bus.ExIsLoad), 32'(e.is_load));
      cmp(e.name, "IdStall",  32'(bus.IdStall),  32'(e.stall));
      if (e.valid) cmp(e.name, "ExDstAddr", 32'(bus.ExDstAddr), 32'(e.dst));
      if (e.chk_ops) begin
         cmp(e.name, "ExOp0", bus.ExOp0, e.op0);
         cmp(e.name, "ExOp1", bus.ExOp1, e.op1);
      end
   endtask

   task automatic expect_out(input string name, input logic valid, input logic we_n, input logic is_load,
                             input logic [4:0] dst, input bit chk_ops, input logic [31:0] op0,
                             input logic [31:0] op1, input logic stall);
      exp_t e;
      e.name    = name;
      e.valid   = valid;
      e.we_n    = we_n;
      e.is_load = is_load;
      e.dst     = dst;
      e.chk_ops = chk_ops;
      e.op0     = op0;
      e.op1     = op1;
      e.stall   = stall;
      sb.push_back(e);
   endtask

   task automatic apply_stimulus(input logic valid, input logic [4:0] rs0, input logic [4:0] rs1,
                                 input logic use0, input logic use1, input logic [4:0] rd,
                                 input logic we_n, input logic is_load);
      bus.IdValid   = valid;
      bus.IdRsAddr0 = rs0;
      bus.IdRsAddr1 = rs1;
      bus.IdRsUse0  = use0;
      bus.IdRsUse1  = use1;
      bus.IdRdAddr  = rd;
      bus.IdRdWE_   = we_n;
      bus.IdIsLoad  = is_load;
   endtask

   task automatic next_cycle();
      @(negedge clk);
      #1;
   endtask

   // Monitor: compare one queued expectation per cycle, just before the rising edge
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (sb.size() > 0) check_output(sb.pop_front());
      end
   end

   initial begin
      reset_         = 1'b0;
      bus.RdData0    = '0;
      bus.RdData1    = '0;
      bus.ExFwdData  = '0;
      bus.MemRdAddr  = '0;
      bus.MemRdWE_   = 1'b1;
      bus.MemFwdData = '0;
      bus.Flush      = 1'b0;
      bus.DsStall    = 1'b0;
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);

      // Reset values
      next_cycle();
      expect_out("reset_values", 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0);

      // Run, then reset again mid-run
      next_cycle();
      reset_ = 1'b1;
      bus.RdData0 = 32'hA; bus.RdData1 = 32'hB;
      apply_stimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0);
      expect_out("after_release", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

      next_cycle();
      bus.RdData0 = 32'hC; bus.RdData1 = 32'hD;
      apply_stimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0);
      expect_out("first_issue", 1'b1, 1'b0, 1'b0, 5'd6, 1'b1, 32'hA, 32'hB, 1'b0);

      next_cycle();
      reset_ = 1'b0;
      expect_out("reset_mid_run", 1'b0, 1'b1, 1'b0, 5'd0, 1'b1, 32'h0, 32'h0, 1'b0);

      // r3 + r4 from the register file
      next_cycle();
      reset_ = 1'b1;
      bus.RdData0 = 32'd5; bus.RdData1 = 32'd7;
      apply_stimulus(1'b1, 5'd3, 5'd4, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
      expect_out("issue_r3_r4", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

      // Downstream stall for three cycles
      next_cycle();
      bus.DsStall = 1'b1;
      bus.RdData0 = 32'h66; bus.RdData1 = 32'h44;
      apply_stimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0);
      expect_out("r3_r4_result", 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 32'd5, 32'd7, 1'b1);

      next_cycle();
      bus.RdData0 = 32'h77;
      expect_out("ds_stall_2", 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 32'd5, 32'd7, 1'b1);

      next_cycle();
      expect_out("ds_stall_3", 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 32'd5, 32'd7, 1'b1);

      next_cycle();
      bus.DsStall = 1'b0;
      expect_out("ds_release", 1'b1, 1'b0, 1'b0, 5'd8, 1'b1, 32'd5, 32'd7, 1'b0);

      // Load into EX, then flush together with load-use and downstream stall
      next_cycle();
      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd13, 1'b0, 1'b1);
      expect_out("after_stall_load", 1'b1, 1'b0, 1'b0, 5'd9, 1'b1, 32'h77, 32'h44, 1'b0);

      next_cycle();
      bus.Flush = 1'b1; bus.DsStall = 1'b1;
      apply_stimulus(1'b1, 5'd13, 5'd0, 1'b1, 1'b0, 5'd14, 1'b0, 1'b0);
      expect_out("flush_cycle", 1'b1, 1'b0, 1'b1, 5'd13, 1'b0, 32'h0, 32'h0, 1'b0);

      next_cycle();
      bus.Flush = 1'b0; bus.DsStall = 1'b0;
      apply_stimulus(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd14, 1'b0, 1'b0);
      expect_out("flush_bubble", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

      next_cycle();
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      expect_out("run_after_flush", 1'b1, 1'b0, 1'b0, 5'd14, 1'b1, 32'h77, 32'h44, 1'b0);

      next_cycle();
      expect_out("invalid_id", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

`ifdef OPFETCH_FWD_EN
      // EX beats MEM on r3
      next_cycle();
      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0);
      expect_out("idle_before_fwd", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

      next_cycle();
      bus.RdData0 = 32'h55; bus.RdData1 = 32'h44;
      bus.ExFwdData = 32'h11;
      bus.MemRdAddr = 5'd3; bus.MemRdWE_ = 1'b0; bus.MemFwdData = 32'h22;
      apply_stimulus(1'b1, 5'd3, 5'd0, 1'b1, 1'b1, 5'd10, 1'b0, 1'b0);
      expect_out("ex_writes_r3", 1'b1, 1'b0, 1'b0, 5'd3, 1'b0, 32'h0, 32'h0, 1'b0);

      // MEM-only match on port 0, EX match on port 1; issue a load to r5
      next_cycle();
      bus.ExFwdData = 32'h33;
      apply_stimulus(1'b1, 5'd3, 5'd10, 1'b1, 1'b1, 5'd5, 1'b0, 1'b1);
      expect_out("ex_beats_mem", 1'b1, 1'b0, 1'b0, 5'd10, 1'b1, 32'h11, 32'h44, 1'b0);

      // Load-use on r5
      next_cycle();
      bus.MemRdWE_ = 1'b1;
      bus.RdData0 = 32'h66;
      apply_stimulus(1'b1, 5'd1, 5'd5, 1'b1, 1'b1, 5'd11, 1'b0, 1'b0);
      expect_out("load_use_stall", 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 32'h22, 32'h33, 1'b1);

      next_cycle();
      bus.MemRdAddr = 5'd5; bus.MemRdWE_ = 1'b0; bus.MemFwdData = 32'h99;
      expect_out("load_use_bubble", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

      next_cycle();
      bus.MemRdWE_ = 1'b1;
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      expect_out("load_mem_fwd", 1'b1, 1'b0, 1'b0, 5'd11, 1'b1, 32'h66, 32'h99, 1'b0);
`else
      // ALU writer of r2 in EX, reader in ID: two bubbles, then register file data
      next_cycle();
      apply_stimulus(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
      expect_out("idle_before_nofwd", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

      next_cycle();
      bus.RdData0 = 32'h55; bus.RdData1 = 32'h21;
      bus.ExFwdData = 32'h11; bus.MemFwdData = 32'h22;
      apply_stimulus(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 5'd15, 1'b0, 1'b0);
      expect_out("nofwd_ex_hazard", 1'b1, 1'b0, 1'b0, 5'd2, 1'b0, 32'h0, 32'h0, 1'b1);

      next_cycle();
      bus.MemRdAddr = 5'd2; bus.MemRdWE_ = 1'b0;
      expect_out("nofwd_mem_hazard", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b1);

      next_cycle();
      bus.MemRdWE_ = 1'b1;
      bus.RdData0 = 32'h5A;
      expect_out("nofwd_second_bubble", 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 32'h0, 32'h0, 1'b0);

      next_cycle();
      apply_stimulus(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0);
      expect_out("nofwd_rf_operand", 1'b1, 1'b0, 1'b0, 5'd15, 1'b1, 32'h5A, 32'h21, 1'b0);
`endif

      // Let the monitor drain the queue, bounded
      repeat (3) @(negedge clk);
      #4;
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_opfetch.md
# id_opfetch

Decode-side operand fetch stage. Takes decoded source/destination fields from the IF/ID register, drives the general-purpose register file's two read ports, and resolves RAW hazards against the EX and MEM stages by forwarding or stalling. Produces the registered ID/EX operand bundle consumed by the execute stage. Register-file writeback bypass is already inside the register file, so this block forwards only from EX and MEM.

## Interface
Parameters:
- `DATA_W`, 32: operand width (`WORD_DATA_W`).
- `ADDR_W`, 5: register address width (`REG_ADDR_BUS`).

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset_`  in  1: asynchronous, active-low reset.
- `IdValid`  in  1: IF/ID holds a real instruction.
- `IdRsAddr0`, `IdRsAddr1`  in  ADDR_W: source register addresses.
- `IdRsUse0`, `IdRsUse1`  in  1: source is actually read (active high).
- `IdRdAddr`  in  ADDR_W: destination register.
- `IdRdWE_`  in  1: destination write enable, active low.
- `IdIsLoad`  in  1: instruction is a load.
- `RdAddr0`, `RdAddr1`  out  ADDR_W: register-file read addresses.
- `RdData0`, `RdData1`  in  DATA_W: register-file read data (combinational).
- `ExFwdData`  in  DATA_W: EX-stage ALU result.
- `MemRdAddr`  in  ADDR_W; `MemRdWE_`  in  1; `MemFwdData`  in  DATA_W: MEM-stage destination and result.
- `Flush`  in  1: discard ID contents (branch/exception).
- `DsStall`  in  1: downstream stage cannot accept.
- `IdStall`  out  1: hold IF/ID and PC.
- `ExValid`  out  1; `ExOp0`, `ExOp1`  out  DATA_W; `ExDstAddr`  out  ADDR_W; `ExDstWE_`  out  1; `ExIsLoad`  out  1: ID/EX register.

## Operation
- `RdAddr0/1` = `IdRsAddr0/1`, combinational, always.
- Source operand select per port i (only if `IdRsUse_i`): EX match (`ExValid`, `ExDstWE_`=0, `ExDstAddr`==addr, not `ExIsLoad`) → `ExFwdData`; else MEM match (`MemRdWE_`=0, `MemRdAddr`==addr) → `MemFwdData`; else `RdData_i`. EX beats MEM. Register 0 has no special treatment.
- Load-use hazard: EX match on a used source while `ExIsLoad`=1 → insert bubble.
- FSM states: RUN, HOLD.
  - RUN: `DsStall`=1 → HOLD, ID/EX unchanged. Hazard → ID/EX loads bubble (`ExValid`=0, `ExDstWE_`=1), `IdStall`=1. Otherwise load ID fields, `ExValid`=`IdValid`.
  - HOLD: ID/EX frozen, `IdStall`=1; leave to RUN on the first cycle `DsStall`=0 (that cycle behaves as RUN).
- Priority: reset > `Flush` > `DsStall` > hazard > advance. `Flush` loads a bubble in any state, returns to RUN, `IdStall`=0.
- A bubble never asserts `ExDstWE_` low or `ExIsLoad`.

## Timing
- Reset values: `ExValid`=0, `ExOp0/1`=0, `ExDstAddr`=0, `ExDstWE_`=1, `ExIsLoad`=0, state RUN.
- Latency 1 cycle: ID fields at edge N appear on ID/EX outputs after edge N.
- `IdStall` combinational from current inputs/state; asserted the same cycle as the hazard or `DsStall`.
- Load-use costs exactly one bubble; next cycle the load is in MEM and is forwarded from `MemFwdData`.
- Reset asserted mid-stall: outputs to reset values immediately, state RUN.

## Configuration
- `OPFETCH_FWD_EN` defined: forwarding as above.
- Undefined: no forwarding; any used source matching a valid EX or MEM destination stalls (bubble, `IdStall`=1) until the writer leaves MEM; operands come only from `RdData0/1`.

## Structure
- Shared CPU header: `WORD_DATA_BUS`, `REG_ADDR_BUS`, `ENABLE_`/`DISABLE_`, `RESET_ENABLE`, `RESET_EDGE`, FSM state encodings `OPF_RUN`/`OPF_HOLD`.
- One sub-module `opfetch_fwd_mux`: per-port match and select (instantiated twice), also returning the load-use/no-forward hazard flag.

## Test plan
- Reset low mid-run → `ExValid`=0, `ExDstWE_`=1, `ExOp0`=0 within the reset cycle; release, issue r3+r4 with `RdData0`=5, `RdData1`=7 → `ExOp0`=5, `ExOp1`=7 after one edge.
- EX writes r3 (`ExFwdData`=0x11), MEM writes r3 (`MemFwdData`=0x22), ID reads r3 → `ExOp0`=0x11.
- EX is load to r5, ID reads r5 → one bubble, `IdStall`=1 one cycle; next cycle `MemFwdData`=0x99 → `ExOp1`=0x99.
- `DsStall`=1 for 3 cycles → ID/EX frozen, `IdStall`=1 throughout; release → new ID contents loaded next edge.
- `Flush`=1 together with load-use hazard and `DsStall` → bubble loaded, `IdStall`=0, state RUN.
- Without `OPFETCH_FWD_EN`: ALU in EX writes r2, ID reads r2 → 2 bubbles, then `ExOp0`=`RdData0`.
